// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM state encodings
// and the default memory geometry.
package dmem_port_arbiter_pkg;
    localparam int DATA_WIDTH         = 16;
    localparam int DATA_MEM_ADDR_SIZE = 10;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BURST = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_t;
endpackage

// File: rtl/dmem_port_arbiter_starve.sv
// Saturating count of consecutive cycles a pending GPU request has lost arbitration.
module arb_starve_counter #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);
    import dmem_port_arbiter_pkg::*;

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + 1'b1;
        end
    end

    assign sat = (count == CW'(LIMIT));
endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between single-word CPU accesses and
// fixed-length GPU bursts; the losing requester is stalled.
//   state     | meaning
//   ARB_IDLE  | arbitrate; a CPU access or GPU beat 0 issues this cycle
//   ARB_BURST | issue GPU beats 1..GPU_BURST-1, CPU stalled
//   ARB_DRAIN | vector load only: wait for the last read word, no access
module dmem_port_arbiter #(
    parameter int DATA_WIDTH   = dmem_port_arbiter_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH   = dmem_port_arbiter_pkg::DATA_MEM_ADDR_SIZE,
    parameter int GPU_BURST    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                            I_CLOCK,
    input  logic                            I_RESET,
    input  logic                            I_CPU_Req,
    input  logic                            I_CPU_WE,
    input  logic [15:0]                     I_CPU_Addr,
    input  logic [DATA_WIDTH-1:0]           I_CPU_WData,
    output logic                            O_CPU_Gnt,
    output logic                            O_CPU_RValid,
    output logic [DATA_WIDTH-1:0]           O_CPU_RData,
    output logic                            O_CPU_Stall,
    input  logic                            I_GPU_Req,
    input  logic                            I_GPU_WE,
    input  logic [15:0]                     I_GPU_Addr,
    input  logic [DATA_WIDTH*GPU_BURST-1:0] I_GPU_WData,
    output logic                            O_GPU_Gnt,
    output logic                            O_GPU_RValid,
    output logic [DATA_WIDTH*GPU_BURST-1:0] O_GPU_RData,
    output logic                            O_GPU_Busy,
    output logic                            O_MEM_En,
    output logic                            O_MEM_WE,
    output logic [ADDR_WIDTH-1:0]           O_MEM_Addr,
    output logic [DATA_WIDTH-1:0]           O_MEM_WData,
    input  logic [DATA_WIDTH-1:0]           I_MEM_RData
);
    import dmem_port_arbiter_pkg::*;

    localparam int VW = DATA_WIDTH * GPU_BURST;
    localparam int BW = $clog2(GPU_BURST);
    localparam logic [BW-1:0] LAST_BEAT = BW'(GPU_BURST - 1);

    arb_state_t          state;
    logic [BW-1:0]       beat;
    logic [ADDR_WIDTH-1:0] base_q;
    logic                burst_we;
    logic [VW-1:0]       wdata_q;
    logic [VW-1:0]       lane_buf;
    logic [VW-1:0]       lane_vec;
    logic                lane_pend;
    logic [BW-1:0]       lane_idx;
    logic                cpu_rd_pend;
    logic                cpu_win;
    logic                gpu_win;
    logic                burst_beat;
    logic                starve_sat;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^{I_CPU_Addr[15:ADDR_WIDTH+1], I_CPU_Addr[0],
                                I_GPU_Addr[15:ADDR_WIDTH+1], I_GPU_Addr[0]};

    arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk   (I_CLOCK),
        .reset (I_RESET),
        .inc   (I_GPU_Req && !gpu_win && !I_RESET),
        .clr   (gpu_win),
        .sat   (starve_sat)
    );

    // Nothing issues while reset is held, so a burst cut by reset stops at once.
    always_comb begin
        cpu_win     = 1'b0;
        gpu_win     = 1'b0;
        burst_beat  = 1'b0;
        O_MEM_En    = 1'b0;
        O_MEM_WE    = 1'b0;
        O_MEM_Addr  = '0;
        O_MEM_WData = '0;
        if (!I_RESET) begin
            if (state == ARB_IDLE) begin
                if (I_GPU_Req && (!I_CPU_Req || starve_sat)) begin
                    gpu_win = 1'b1;
                end else if (I_CPU_Req) begin
                    cpu_win = 1'b1;
                end
            end else if (state == ARB_BURST) begin
                burst_beat = 1'b1;
            end
        end
        if (cpu_win) begin
            O_MEM_En    = 1'b1;
            O_MEM_WE    = I_CPU_WE;
            O_MEM_Addr  = I_CPU_Addr[ADDR_WIDTH:1];
            O_MEM_WData = I_CPU_WData;
        end else if (gpu_win) begin
            O_MEM_En    = 1'b1;
            O_MEM_WE    = I_GPU_WE;
            O_MEM_Addr  = I_GPU_Addr[ADDR_WIDTH:1];
            O_MEM_WData = I_GPU_WData[DATA_WIDTH-1:0];
        end else if (burst_beat) begin
            O_MEM_En    = 1'b1;
            O_MEM_WE    = burst_we;
            O_MEM_Addr  = base_q + ADDR_WIDTH'(beat);
            O_MEM_WData = wdata_q[int'(beat)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        lane_vec = lane_buf;
        lane_vec[int'(lane_idx)*DATA_WIDTH +: DATA_WIDTH] = I_MEM_RData;
    end

    assign O_CPU_Gnt   = cpu_win;
    assign O_GPU_Gnt   = gpu_win;
    assign O_CPU_Stall = I_CPU_Req && !cpu_win && !I_RESET;
    assign O_GPU_Busy  = (state != ARB_IDLE) && !I_RESET;

    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            state        <= ARB_IDLE;
            beat         <= '0;
            base_q       <= '0;
            burst_we     <= 1'b0;
            wdata_q      <= '0;
            lane_buf     <= '0;
            lane_pend    <= 1'b0;
            lane_idx     <= '0;
            cpu_rd_pend  <= 1'b0;
            O_CPU_RValid <= 1'b0;
            O_CPU_RData  <= '0;
            O_GPU_RValid <= 1'b0;
            O_GPU_RData  <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (gpu_win) begin
                        state    <= ARB_BURST;
                        beat     <= BW'(1);
                        base_q   <= I_GPU_Addr[ADDR_WIDTH:1];
                        burst_we <= I_GPU_WE;
                        wdata_q  <= I_GPU_WData;
                    end
                end
                ARB_BURST: begin
                    if (beat == LAST_BEAT) begin
                        beat  <= '0;
                        state <= burst_we ? ARB_IDLE : ARB_DRAIN;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase

            // Read data returns one cycle after issue; track which requester owns it.
            cpu_rd_pend  <= cpu_win && !I_CPU_WE;
            O_CPU_RValid <= cpu_rd_pend;
            if (cpu_rd_pend) begin
                O_CPU_RData <= I_MEM_RData;
            end

            lane_pend    <= (gpu_win && !I_GPU_WE) || (burst_beat && !burst_we);
            lane_idx     <= gpu_win ? '0 : beat;
            O_GPU_RValid <= 1'b0;
            if (lane_pend) begin
                lane_buf <= lane_vec;
                if (lane_idx == LAST_BEAT) begin
                    O_GPU_RData  <= lane_vec;
                    O_GPU_RValid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: directed traffic pushes expected
// memory accesses and read data; a monitor pops and compares on DUT events.
module tb_dmem_port_arbiter;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam int NB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             cpu_req, cpu_we;
    logic [15:0]      cpu_addr;
    logic [DW-1:0]    cpu_wdata;
    logic             cpu_gnt, cpu_rvalid, cpu_stall;
    logic [DW-1:0]    cpu_rdata;
    logic             gpu_req, gpu_we;
    logic [15:0]      gpu_addr;
    logic [DW*NB-1:0] gpu_wdata;
    logic             gpu_gnt, gpu_rvalid, gpu_busy;
    logic [DW*NB-1:0] gpu_rdata;
    logic             mem_en, mem_we;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic [DW-1:0]    mem_rdata;

    dmem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .GPU_BURST(NB), .STARVE_LIMIT(8)) dut (
        .I_CLOCK(clk), .I_RESET(rst),
        .I_CPU_Req(cpu_req), .I_CPU_WE(cpu_we), .I_CPU_Addr(cpu_addr), .I_CPU_WData(cpu_wdata),
        .O_CPU_Gnt(cpu_gnt), .O_CPU_RValid(cpu_rvalid), .O_CPU_RData(cpu_rdata), .O_CPU_Stall(cpu_stall),
        .I_GPU_Req(gpu_req), .I_GPU_WE(gpu_we), .I_GPU_Addr(gpu_addr), .I_GPU_WData(gpu_wdata),
        .O_GPU_Gnt(gpu_gnt), .O_GPU_RValid(gpu_rvalid), .O_GPU_RData(gpu_rdata), .O_GPU_Busy(gpu_busy),
        .O_MEM_En(mem_en), .O_MEM_WE(mem_we), .O_MEM_Addr(mem_addr), .O_MEM_WData(mem_wdata),
        .I_MEM_RData(mem_rdata)
    );

    // Synchronous single-port RAM: read data valid the cycle after issue.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          mem_init;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
            mem[8] <= 16'hBEEF;
            for (int i = 0; i < 4; i++) mem[16+i] <= DW'(i + 1);
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } acc_t;

    acc_t             acc_q[$];
    logic [DW-1:0]    cpu_q[$];
    logic [DW*NB-1:0] gpu_q[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_acc(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        acc_t e;
        e.we = we; e.addr = a; e.wdata = d;
        acc_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((cpu_q.size() + gpu_q.size() + acc_q.size()) != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(cpu_q.size() + gpu_q.size() + acc_q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        acc_t e;
        if (mem_en) begin
            if (acc_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL mem_unexpected: got access we=%b addr=%0h, expected none", mem_we, mem_addr);
            end else begin
                e = acc_q.pop_front();
                check("mem_access", 64'({mem_we, mem_addr, mem_we ? mem_wdata : 16'h0}), 64'(e));
            end
        end
        if (cpu_rvalid) begin
            if (cpu_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL cpu_rvalid_unexpected: got rdata %0h, expected no pulse", cpu_rdata);
            end else begin
                check("cpu_rdata", 64'(cpu_rdata), 64'(cpu_q.pop_front()));
            end
        end
        if (gpu_rvalid) begin
            if (gpu_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL gpu_rvalid_unexpected: got rdata %0h, expected no pulse", gpu_rdata);
            end else begin
                check("gpu_rdata", gpu_rdata, gpu_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_n, stall_n, rv_n;
        rst = 1'b1; mem_init = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        gpu_req = 0; gpu_we = 0; gpu_addr = '0; gpu_wdata = '0;
        repeat (3) cyc();
        rst = 1'b0; mem_init = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_ctrl", 64'({cpu_gnt, cpu_rvalid, cpu_stall, gpu_gnt, gpu_rvalid, gpu_busy, mem_en, mem_we}), 64'd0);
        end
        check("idle_cpu_rdata", 64'(cpu_rdata), 64'd0);
        check("idle_gpu_rdata", gpu_rdata, 64'd0);
        check("idle_mem_bus", 64'({mem_addr, mem_wdata}), 64'd0);

        // CPU load of line 8
        cyc();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        exp_acc(1'b0, AW'(8), '0);
        cpu_q.push_back(16'hBEEF);
        @(negedge clk);
        check("cpu_gnt", 64'(cpu_gnt), 64'd1);
        check("cpu_stall", 64'(cpu_stall), 64'd0);
        cyc();
        cpu_req = 0;
        drain("cpu_load_done");

        // GPU vector load of lines 16..19
        cyc();
        gpu_req = 1; gpu_we = 0; gpu_addr = 16'h0020;
        for (int i = 0; i < 4; i++) exp_acc(1'b0, AW'(16 + i), '0);
        gpu_q.push_back(64'h0004_0003_0002_0001);
        @(negedge clk);
        check("gpu_load_gnt", 64'(gpu_gnt), 64'd1);
        busy_n = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (i == 0) gpu_req = 0;
            @(negedge clk);
            if (gpu_busy) busy_n++;
        end
        check("gpu_busy_cycles", 64'(busy_n), 64'd4);
        drain("gpu_load_done");

        // Contention: CPU wins until the GPU has lost 8 cycles in a row
        cyc();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        gpu_req = 1; gpu_we = 1; gpu_addr = 16'h0100; gpu_wdata = 64'hA003_A002_A001_A000;
        for (int c = 0; c < 8; c++) begin
            exp_acc(1'b0, AW'(8), '0);
            cpu_q.push_back(16'hBEEF);
        end
        for (int k = 0; k < 4; k++) exp_acc(1'b1, AW'(10'h80 + k), DW'(16'hA000 + k));
        exp_acc(1'b0, AW'(8), '0);
        cpu_q.push_back(16'hBEEF);
        stall_n = 0;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            check($sformatf("contend_cpu_gnt_c%0d", c), 64'(cpu_gnt), 64'((c < 8 || c == 12) ? 1 : 0));
            check($sformatf("contend_gpu_gnt_c%0d", c), 64'(gpu_gnt), 64'((c == 8) ? 1 : 0));
            if (cpu_stall) stall_n++;
            cyc();
            if (c == 8) gpu_req = 0;
        end
        cpu_req = 0;
        check("contend_stall_cycles", 64'(stall_n), 64'd4);
        drain("contend_done");

        // GPU store wrapping past the top line; a CPU request drops while stalled
        cyc();
        gpu_req = 1; gpu_we = 1; gpu_addr = 16'h07FC; gpu_wdata = 64'h4444_3333_2222_1111;
        exp_acc(1'b1, AW'(10'h3FE), 16'h1111);
        exp_acc(1'b1, AW'(10'h3FF), 16'h2222);
        exp_acc(1'b1, AW'(10'h000), 16'h3333);
        exp_acc(1'b1, AW'(10'h001), 16'h4444);
        @(negedge clk);
        check("wrap_gnt", 64'(gpu_gnt), 64'd1);
        cyc();
        gpu_req = 0;
        cyc();
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0040; cpu_wdata = 16'hDEAD;
        @(negedge clk);
        check("wrap_cpu_stall", 64'({cpu_stall, cpu_gnt}), 64'b10);
        cyc();
        cpu_req = 0;
        drain("wrap_done");
        check("wrap_mem_3fe", 64'(mem[10'h3FE]), 64'h1111);
        check("wrap_mem_3ff", 64'(mem[10'h3FF]), 64'h2222);
        check("wrap_mem_000", 64'(mem[10'h000]), 64'h3333);
        check("wrap_mem_001", 64'(mem[10'h001]), 64'h4444);
        check("dropped_req_no_write", 64'(mem[32]), 64'h0);

        // Reset after beat 1 of a vector load
        cyc();
        gpu_req = 1; gpu_we = 0; gpu_addr = 16'h0020;
        exp_acc(1'b0, AW'(16), '0);
        exp_acc(1'b0, AW'(17), '0);
        @(negedge clk);
        check("rst_gpu_gnt", 64'(gpu_gnt), 64'd1);
        cyc();
        gpu_req = 0;
        @(negedge clk);
        check("rst_busy_beat1", 64'(gpu_busy), 64'd1);
        cyc();
        rst = 1;
        @(negedge clk);
        check("rst_no_access", 64'(mem_en), 64'd0);
        cyc();
        rst = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        exp_acc(1'b0, AW'(8), '0);
        cpu_q.push_back(16'hBEEF);
        @(negedge clk);
        check("rst_cpu_gnt", 64'(cpu_gnt), 64'd1);
        check("rst_busy_after", 64'(gpu_busy), 64'd0);
        cyc();
        cpu_req = 0;
        rv_n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (gpu_rvalid) rv_n++;
        end
        check("rst_no_gpu_rvalid", 64'(rv_n), 64'd0);
        drain("rst_done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
